pipe_stage_chain: RTL and testbench

Parametrised, elastic successor to the fixed per-stage pipeline registers. It provides a chain of DEPTH register stages carrying a data bundle and a control bundle, with a per-stage valid bit and a valid/ready handshake at both ends. Bubbles collapse: an empty stage fills even while later stages are blocked. A global stall (hazard hold) and a synchronous flush (branch kill) are included, so the hazard and branch units can drive any stage boundary of the CPU through one block.

---
 rtl/pipe_stage_chain.sv | 113 +++++++++++
 tb/tb_pipe_stage_chain.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_chain.sv
// Elastic chain of DEPTH register stages carrying a data and a control bundle with
// per-stage valid, valid/ready at both ends, global stall, flush and bubble collapse.
module pipe_stage_chain #(
  parameter int                DATA_W   = 32,
  parameter int                CTRL_W   = 8,
  parameter int                DEPTH    = 1,
  parameter logic [CTRL_W-1:0] CTRL_CLR = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [CTRL_W-1:0]          in_ctrl,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [CTRL_W-1:0]          out_ctrl,
  input  logic                       stall,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]  vld_p;
  logic [DATA_W-1:0] data_p [DEPTH];
  logic [CTRL_W-1:0] ctrl_p [DEPTH];

  logic [DEPTH-1:0]  vld_nxt;
  logic [DATA_W-1:0] data_nxt [DEPTH];
  logic [CTRL_W-1:0] ctrl_nxt [DEPTH];

  logic [DEPTH-1:0]  src_vld;
  logic [DATA_W-1:0] src_data [DEPTH];
  logic [CTRL_W-1:0] src_ctrl [DEPTH];

  logic [DEPTH-1:0]  en;

  function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [OCC_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) cnt = cnt + OCC_W'(v[i]);
    return cnt;
  endfunction

  // Enables ripple back from the output so an empty stage can fill behind a blocked one.
  always_comb begin : en_chain
    logic carry;
    carry = out_ready;
    en    = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      carry = !stall && (!vld_p[i] || carry);
      en[i] = carry;
    end
  end

  assign in_ready  = en[0] && !flush;
  assign out_valid = vld_p[DEPTH-1] && !stall && !flush;
  assign out_data  = data_p[DEPTH-1];
  assign out_ctrl  = ctrl_p[DEPTH-1];

  always_comb begin
    src_vld[0]  = in_valid;
    src_data[0] = in_data;
    src_ctrl[0] = in_ctrl;
    for (int i = 1; i < DEPTH; i++) begin
      src_vld[i]  = vld_p[i-1];
      src_data[i] = data_p[i-1];
      src_ctrl[i] = ctrl_p[i-1];
    end
  end

  // Invalidated stages always carry CTRL_CLR so a squashed bundle cannot write downstream.
  always_comb begin
    vld_nxt  = vld_p;
    data_nxt = data_p;
    ctrl_nxt = ctrl_p;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush) begin
        vld_nxt[i]  = 1'b0;
        ctrl_nxt[i] = CTRL_CLR;
      end else if (en[i]) begin
        if (src_vld[i]) begin
          vld_nxt[i]  = 1'b1;
          data_nxt[i] = src_data[i];
          ctrl_nxt[i] = src_ctrl[i];
        end else begin
          vld_nxt[i]  = 1'b0;
          ctrl_nxt[i] = CTRL_CLR;
        end
      end
    end
  end

  // Stage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p     <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_p[i] <= '0;
        ctrl_p[i] <= CTRL_CLR;
      end
    end else begin
      vld_p     <= vld_nxt;
      data_p    <= data_nxt;
      ctrl_p    <= ctrl_nxt;
      occupancy <= popcount(vld_nxt);
    end
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain: a DEPTH=3 instance and a DEPTH=2 instance
// exercised with hand-computed stream, backpressure, bubble, flush, stall and reset vectors.
module tb_pipe_stage_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // DEPTH=3 instance
  logic        a_rst = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0, a_stall = 1'b0, a_flush = 1'b0;
  logic        a_in_ready, a_out_valid;
  logic [31:0] a_in_data = '0, a_out_data;
  logic [7:0]  a_in_ctrl = '0, a_out_ctrl;
  logic [1:0]  a_occ;

  // DEPTH=2 instance
  logic        b_rst = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0, b_stall = 1'b0, b_flush = 1'b0;
  logic        b_in_ready, b_out_valid;
  logic [31:0] b_in_data = '0, b_out_data;
  logic [7:0]  b_in_ctrl = '0, b_out_ctrl;
  logic [1:0]  b_occ;

  pipe_stage_chain #(.DATA_W(32), .CTRL_W(8), .DEPTH(3), .CTRL_CLR(8'h00)) dut_a (
    .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_ctrl(a_in_ctrl), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
    .stall(a_stall), .flush(a_flush), .occupancy(a_occ)
  );

  pipe_stage_chain #(.DATA_W(32), .CTRL_W(8), .DEPTH(2), .CTRL_CLR(8'h00)) dut_b (
    .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_ctrl(b_in_ctrl), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
    .stall(b_stall), .flush(b_flush), .occupancy(b_occ)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int occ1 [7] = '{1, 2, 3, 3, 2, 1, 0};

  initial begin
    // Reset state
    a_rst = 1'b1; b_rst = 1'b1;
    tick();
    check_eq("rst_a_occ", a_occ, 0);
    check_eq("rst_a_out_valid", a_out_valid, 0);
    check_eq("rst_a_out_data", a_out_data, 0);
    check_eq("rst_a_out_ctrl", a_out_ctrl, 0);
    check_eq("rst_a_in_ready", a_in_ready, 1);
    check_eq("rst_b_occ", b_occ, 0);
    a_rst = 1'b0; b_rst = 1'b0;

    // Streaming through DEPTH=3 with out_ready held high
    a_out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      a_in_valid = (k < 4);
      a_in_data  = 32'h11 * (k + 1);
      a_in_ctrl  = 8'(k + 1);
      tick();
      check_eq($sformatf("stream_valid_%0d", k), a_out_valid, (k >= 2 && k <= 5));
      if (k >= 2 && k <= 5) begin
        check_eq($sformatf("stream_data_%0d", k), a_out_data, 32'h11 * (k - 1));
        check_eq($sformatf("stream_ctrl_%0d", k), a_out_ctrl, 8'(k - 1));
      end
      check_eq($sformatf("stream_occ_%0d", k), a_occ, occ1[k]);
    end

    // Fill to full, backpressure, then one-in/one-out
    a_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a_in_valid = 1'b1;
      a_in_data  = 32'h11 * (k + 1);
      tick();
    end
    check_eq("full_occ", a_occ, 3);
    a_in_data = 32'h44;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq("bp_in_ready", a_in_ready, 0);
      check_eq("bp_out_valid", a_out_valid, 1);
      check_eq("bp_out_data", a_out_data, 32'h11);
      check_eq("bp_occ", a_occ, 3);
      tick();
    end
    a_out_ready = 1'b1;
    #1;
    check_eq("release_in_ready", a_in_ready, 1);
    tick();
    check_eq("thru_out_data", a_out_data, 32'h22);
    check_eq("thru_occ", a_occ, 3);
    a_in_valid = 1'b0;
    tick();
    check_eq("drain_data_33", a_out_data, 32'h33);
    check_eq("drain_occ_2", a_occ, 2);
    tick();
    check_eq("drain_data_44", a_out_data, 32'h44);
    check_eq("drain_occ_1", a_occ, 1);
    tick();
    check_eq("drain_empty_valid", a_out_valid, 0);
    check_eq("drain_empty_occ", a_occ, 0);

    // Bubble collapse: build valid=[1,0,1] then fill the hole while the output is blocked
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 32'hA1;
    tick();
    a_in_valid = 1'b0;
    tick();
    tick();
    check_eq("bub_occ_1", a_occ, 1);
    check_eq("bub_out_a1", a_out_data, 32'hA1);
    a_in_valid = 1'b1; a_in_data = 32'hB2;
    tick();
    check_eq("bub_occ_2", a_occ, 2);
    a_in_data = 32'h55;
    #1;
    check_eq("bub_in_ready", a_in_ready, 1);
    tick();
    a_in_valid = 1'b0;
    #1;
    check_eq("bub_occ_3", a_occ, 3);
    check_eq("bub_full_in_ready", a_in_ready, 0);
    a_out_ready = 1'b1;
    #1;
    check_eq("bub_out0", a_out_data, 32'hA1);
    tick();
    check_eq("bub_out1", a_out_data, 32'hB2);
    tick();
    check_eq("bub_out2", a_out_data, 32'h55);
    tick();
    check_eq("bub_final_occ", a_occ, 0);

    // Flush on DEPTH=2 with two bundles inside
    b_out_ready = 1'b0; b_in_ctrl = 8'hFF;
    b_in_valid = 1'b1; b_in_data = 32'h01;
    tick();
    b_in_data = 32'h02;
    tick();
    check_eq("fl_pre_occ", b_occ, 2);
    check_eq("fl_pre_ctrl", b_out_ctrl, 8'hFF);
    b_flush = 1'b1; b_in_data = 32'h03; b_out_ready = 1'b1;
    #1;
    check_eq("fl_in_ready", b_in_ready, 0);
    check_eq("fl_out_valid", b_out_valid, 0);
    tick();
    b_flush = 1'b0; b_in_valid = 1'b0;
    #1;
    check_eq("fl_occ", b_occ, 0);
    check_eq("fl_out_ctrl", b_out_ctrl, 8'h00);
    check_eq("fl_out_valid_after", b_out_valid, 0);
    tick();
    tick();
    check_eq("fl_nothing_accepted", b_out_valid, 0);
    check_eq("fl_occ_later", b_occ, 0);

    // Stall on a full DEPTH=2 chain
    b_out_ready = 1'b0; b_in_ctrl = 8'h0F;
    b_in_valid = 1'b1; b_in_data = 32'h21;
    tick();
    b_in_data = 32'h22;
    tick();
    b_stall = 1'b1; b_in_data = 32'h23; b_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("st_in_ready", b_in_ready, 0);
      check_eq("st_out_valid", b_out_valid, 0);
      check_eq("st_occ", b_occ, 2);
      check_eq("st_out_data", b_out_data, 32'h21);
      tick();
    end
    b_stall = 1'b0;
    #1;
    check_eq("st_rel_out_valid", b_out_valid, 1);
    check_eq("st_rel_out_data", b_out_data, 32'h21);
    check_eq("st_rel_in_ready", b_in_ready, 1);
    tick();
    check_eq("st_next_data", b_out_data, 32'h22);
    check_eq("st_next_occ", b_occ, 2);
    b_in_valid = 1'b0;
    tick();
    check_eq("st_last_data", b_out_data, 32'h23);
    check_eq("st_last_occ", b_occ, 1);
    tick();
    check_eq("st_empty_occ", b_occ, 0);

    // Reset mid-stream with stall and flush also asserted
    b_out_ready = 1'b0; b_in_ctrl = 8'hFF;
    b_in_valid = 1'b1; b_in_data = 32'h31;
    tick();
    b_in_data = 32'h32;
    tick();
    b_rst = 1'b1; b_stall = 1'b1; b_flush = 1'b1;
    tick();
    check_eq("mr_occ", b_occ, 0);
    check_eq("mr_out_valid", b_out_valid, 0);
    check_eq("mr_out_ctrl", b_out_ctrl, 8'h00);
    check_eq("mr_out_data", b_out_data, 32'h0);
    check_eq("mr_in_ready", b_in_ready, 0);
    b_rst = 1'b0; b_stall = 1'b0; b_flush = 1'b0;
    b_in_valid = 1'b1; b_in_data = 32'hAA; b_in_ctrl = 8'h5A; b_out_ready = 1'b1;
    #1;
    check_eq("mr_accept_ready", b_in_ready, 1);
    tick();
    b_in_valid = 1'b0;
    tick();
    check_eq("mr_aa_valid", b_out_valid, 1);
    check_eq("mr_aa_data", b_out_data, 32'hAA);
    check_eq("mr_aa_ctrl", b_out_ctrl, 8'h5A);
    tick();
    check_eq("mr_done_occ", b_occ, 0);
    check_eq("mr_done_valid", b_out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
